// File: rtl/cache_resp_pkg.sv
// Shared constants and response-entry layout {dest, port, data[, parity]}, parity in bit 0.
// The parity field exists only when RESP_PKT_PARITY_EN is defined.
package cache_resp_pkg;

  localparam int unsigned PORT_NORTH = 0;
  localparam int unsigned PORT_SOUTH = 1;
  localparam int unsigned PORT_EAST  = 2;
  localparam int unsigned PORT_WEST  = 3;
  localparam int unsigned NUM_PORTS  = 4;
  localparam int unsigned PORT_W     = 2;

`ifdef RESP_PKT_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif

  function automatic int unsigned dataLsb();
    return PAR_W;
  endfunction

  function automatic int unsigned portLsb(input int unsigned dataW);
    return PAR_W + dataW;
  endfunction

  function automatic int unsigned destLsb(input int unsigned dataW);
    return PAR_W + dataW + PORT_W;
  endfunction

  function automatic int unsigned entryWidth(input int unsigned dataW, input int unsigned naddrW);
    return PAR_W + dataW + PORT_W + naddrW;
  endfunction

endpackage

// File: rtl/cache_response_packetizer_fifo.sv
// resp_mwsr_fifo: up to four writes and one read per cycle. Active write lanes are
// compacted onto consecutive slots by prefix count; head is fall-through, zero when empty.
module resp_mwsr_fifo
  import cache_resp_pkg::*;
#(
  parameter int unsigned ENTRY_W = 39,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           wrEn,
  input  logic [NUM_PORTS*ENTRY_W-1:0]   wrData,
  input  logic                           rdEn,
  output logic [ENTRY_W-1:0]             headData,
  output logic [$clog2(DEPTH):0]         level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wrPtr;
  logic [AW-1:0]      rdPtr;
  logic [AW-1:0]      wrIdx [NUM_PORTS];
  logic [2:0]         nWr;

  always_comb begin
    nWr = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      wrIdx[p] = wrPtr + AW'(nWr);
      if (wrEn[p]) nWr = nWr + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (wrEn[p]) mem[wrIdx[p]] <= wrData[p*ENTRY_W +: ENTRY_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      wrPtr <= wrPtr + AW'(nWr);
      if (rdEn) rdPtr <= rdPtr + AW'(1);
      level <= level + LW'(nWr) - LW'(rdEn);
    end
  end

  assign headData = (level == '0) ? '0 : mem[rdPtr];

endmodule

// File: rtl/cache_response_packetizer.sv
// Packs per-port cache read responses into a shared FIFO and serialises them as packets,
// dropping and counting responses that do not fit. Optional: RESP_PKT_PARITY_EN adds pktParity_o.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NETWORK_ADDRESS_WIDTH
`define NETWORK_ADDRESS_WIDTH 4
`endif

module cache_response_packetizer
  import cache_resp_pkg::*;
#(
  parameter int unsigned DATA_W     = `DATA_WIDTH,
  parameter int unsigned NADDR_W    = `NETWORK_ADDRESS_WIDTH,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          readReady_i,
  input  logic [NUM_PORTS*NADDR_W-1:0]  reqAddr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   data_i,
  output logic                          pktValid_o,
  input  logic                          pktReady_i,
  output logic [NADDR_W-1:0]            pktDest_o,
  output logic [PORT_W-1:0]             pktPort_o,
  output logic [DATA_W-1:0]             pktData_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o,
  output logic [CNT_W-1:0]              dropCount_o
`ifdef RESP_PKT_PARITY_EN
  ,
  output logic                          pktParity_o
`endif
);

  localparam int unsigned LW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENTRY_W  = entryWidth(DATA_W, NADDR_W);
  localparam int unsigned DATA_LSB = dataLsb();
  localparam int unsigned PORT_LSB = portLsb(DATA_W);
  localparam int unsigned DEST_LSB = destLsb(DATA_W);

  logic                           deq;
  logic [LW:0]                    space;
  logic [NUM_PORTS-1:0]           accMask;
  logic [2:0]                     accCnt;
  logic [2:0]                     nDrop;
  logic [ENTRY_W-1:0]             ent;
  logic [NUM_PORTS*ENTRY_W-1:0]   wrData;
  logic [ENTRY_W-1:0]             headData;
  logic [CNT_W+2:0]               dropSum;

  assign pktValid_o = (level_o != '0);
  assign deq        = pktValid_o & pktReady_i;
  // A dequeue in the same cycle frees one slot, so a full FIFO can still accept one.
  assign space      = (LW+1)'(FIFO_DEPTH) - (LW+1)'(level_o) + (LW+1)'(deq);

  // Lowest-index ports win; anything past the free space is dropped.
  always_comb begin
    accMask = '0;
    accCnt  = '0;
    nDrop   = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (readReady_i[p]) begin
        if ((LW+1)'(accCnt) < space) begin
          accMask[p] = 1'b1;
          accCnt     = accCnt + 3'd1;
        end else begin
          nDrop = nDrop + 3'd1;
        end
      end
    end
  end

  always_comb begin
    wrData = '0;
    ent    = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      ent = '0;
      ent[DEST_LSB +: NADDR_W] = reqAddr_i[p*NADDR_W +: NADDR_W];
      ent[PORT_LSB +: PORT_W]  = PORT_W'(p);
      ent[DATA_LSB +: DATA_W]  = data_i[p*DATA_W +: DATA_W];
`ifdef RESP_PKT_PARITY_EN
      ent[0] = ^{reqAddr_i[p*NADDR_W +: NADDR_W], PORT_W'(p), data_i[p*DATA_W +: DATA_W]};
`endif
      wrData[p*ENTRY_W +: ENTRY_W] = ent;
    end
  end

  resp_mwsr_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (FIFO_DEPTH)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .wrEn     (accMask),
    .wrData   (wrData),
    .rdEn     (deq),
    .headData (headData),
    .level    (level_o)
  );

  assign pktDest_o = headData[DEST_LSB +: NADDR_W];
  assign pktPort_o = headData[PORT_LSB +: PORT_W];
  assign pktData_o = headData[DATA_LSB +: DATA_W];
`ifdef RESP_PKT_PARITY_EN
  assign pktParity_o = headData[0];
`endif

  assign dropSum = {3'b000, dropCount_o} + (CNT_W+3)'(nDrop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_o  <= 1'b0;
      dropCount_o <= '0;
    end else if (nDrop != '0) begin
      overflow_o  <= 1'b1;
      dropCount_o <= (dropSum[CNT_W+2:CNT_W] != 3'b000) ? '1 : dropSum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_cache_response_packetizer.sv
// Scoreboard bench for cache_response_packetizer: main instance (CNT_W=8) plus a CNT_W=2
// instance on the same stimulus for drop-counter saturation.
module tb_cache_response_packetizer;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 8;

  typedef struct {
    logic [AW-1:0] dest;
    logic [1:0]    port;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    readReady;
  logic [4*AW-1:0] reqAddr;
  logic [4*DW-1:0] data;
  logic          pktReady;

  logic          pktValid, pktValidS;
  logic [AW-1:0] pktDest, pktDestS;
  logic [1:0]    pktPort, pktPortS;
  logic [DW-1:0] pktData, pktDataS;
  logic [3:0]    level, levelS;
  logic          overflow, overflowS;
  logic [7:0]    dropCount;
  logic [1:0]    dropCountS;
`ifdef RESP_PKT_PARITY_EN
  logic          pktParity, pktParityS;
`endif

  always #5 clk = ~clk;

  cache_response_packetizer #(
    .DATA_W(DW), .NADDR_W(AW), .FIFO_DEPTH(DEPTH), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .readReady_i(readReady), .reqAddr_i(reqAddr), .data_i(data),
    .pktValid_o(pktValid), .pktReady_i(pktReady), .pktDest_o(pktDest), .pktPort_o(pktPort),
    .pktData_o(pktData), .level_o(level), .overflow_o(overflow), .dropCount_o(dropCount)
`ifdef RESP_PKT_PARITY_EN
    , .pktParity_o(pktParity)
`endif
  );

  cache_response_packetizer #(
    .DATA_W(DW), .NADDR_W(AW), .FIFO_DEPTH(DEPTH), .CNT_W(2)
  ) dutSat (
    .clk(clk), .reset(reset), .readReady_i(readReady), .reqAddr_i(reqAddr), .data_i(data),
    .pktValid_o(pktValidS), .pktReady_i(pktReady), .pktDest_o(pktDestS), .pktPort_o(pktPortS),
    .pktData_o(pktDataS), .level_o(levelS), .overflow_o(overflowS), .dropCount_o(dropCountS)
`ifdef RESP_PKT_PARITY_EN
    , .pktParity_o(pktParityS)
`endif
  );

  int     checks = 0;
  int     errors = 0;
  entry_t q[$];
  logic   expOvf;
  int     expDc;
  int     expDcS;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic setInputs(input logic [3:0] mask);
    readReady = mask;
    for (int p = 0; p < 4; p++) begin
      reqAddr[p*AW +: AW] = AW'($urandom);
      data[p*DW +: DW]    = $urandom;
    end
  endtask

  // Checks head outputs against the scoreboard, advances the model across one edge,
  // then checks the registered state after the edge.
  task automatic step();
    int     sz;
    int     space;
    int     acc;
    int     drops;
    bit     deq;
    entry_t e;
    sz  = q.size();
    deq = (sz != 0) && pktReady;
    checkVal("valid", 64'(pktValid), 64'(sz != 0));
    if (sz != 0) begin
      checkVal("dest", 64'(pktDest), 64'(q[0].dest));
      checkVal("port", 64'(pktPort), 64'(q[0].port));
      checkVal("data", 64'(pktData), 64'(q[0].data));
`ifdef RESP_PKT_PARITY_EN
      checkVal("parity", 64'(pktParity), 64'(^{q[0].dest, q[0].port, q[0].data}));
`endif
    end
    space = DEPTH - sz + int'(deq);
    if (deq) void'(q.pop_front());
    acc   = 0;
    drops = 0;
    for (int p = 0; p < 4; p++) begin
      if (readReady[p]) begin
        if (acc < space) begin
          e.dest = reqAddr[p*AW +: AW];
          e.port = 2'(p);
          e.data = data[p*DW +: DW];
          q.push_back(e);
          acc++;
        end else begin
          drops++;
        end
      end
    end
    if (drops != 0) begin
      expOvf = 1'b1;
      expDc  = (expDc + drops > 255) ? 255 : expDc + drops;
      expDcS = (expDcS + drops > 3) ? 3 : expDcS + drops;
    end
    @(posedge clk);
    #1;
    checkVal("level", 64'(level), 64'(q.size()));
    checkVal("levelSat", 64'(levelS), 64'(q.size()));
    checkVal("overflow", 64'(overflow), 64'(expOvf));
    checkVal("dropCount", 64'(dropCount), 64'(expDc));
    checkVal("dropCountSat", 64'(dropCountS), 64'(expDcS));
  endtask

  task automatic doReset();
    reset     = 1'b0;
    readReady = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    expOvf = 1'b0;
    expDc  = 0;
    expDcS = 0;
    checkVal("rstValid", 64'(pktValid), 64'd0);
    checkVal("rstLevel", 64'(level), 64'd0);
    checkVal("rstOverflow", 64'(overflow), 64'd0);
    checkVal("rstDrop", 64'(dropCount), 64'd0);
    checkVal("rstDropSat", 64'(dropCountS), 64'd0);
    checkVal("rstDest", 64'(pktDest), 64'd0);
    checkVal("rstPort", 64'(pktPort), 64'd0);
    checkVal("rstData", 64'(pktData), 64'd0);
  endtask

  task automatic drain(input int budget);
    pktReady = 1'b1;
    setInputs(4'b0000);
    for (int i = 0; i < budget && q.size() != 0; i++) step();
    checkVal("drained", 64'(q.size()), 64'd0);
    step();
  endtask

  initial begin
    reset     = 1'b0;
    pktReady  = 1'b0;
    readReady = '0;
    reqAddr   = '0;
    data      = '0;
    @(posedge clk);
    #1;
    doReset();

    // single north response with exact values
    setInputs(4'b0001);
    reqAddr[AW-1:0] = 4'h5;
    data[DW-1:0]    = 32'hDEADBEEF;
    pktReady = 1'b1;
    step();
    checkVal("t1dest", 64'(pktDest), 64'h5);
    checkVal("t1data", 64'(pktData), 64'hDEADBEEF);
    setInputs(4'b0000);
    step();
    step();

    // ordering: S and W held, then released
    pktReady = 1'b0;
    setInputs(4'b1010);
    step();
    setInputs(4'b0000);
    step();
    checkVal("t2port", 64'(pktPort), 64'd1);
    drain(10);

    // fill under backpressure, then overflow
    pktReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setInputs(4'b0011);
      step();
    end
    setInputs(4'b1111);
    step();
    checkVal("t3drop4", 64'(dropCount), 64'd4);
    setInputs(4'b1111);
    step();
    checkVal("t5sat", 64'(dropCountS), 64'd3);

    // full with simultaneous dequeue
    pktReady = 1'b1;
    setInputs(4'b0001);
    step();
    checkVal("t4level", 64'(level), 64'd8);

    // random stream across pointer wrap
    for (int i = 0; i < 40; i++) begin
      pktReady = 1'($urandom_range(0, 3) != 0);
      setInputs(4'($urandom));
      step();
    end
    drain(20);

    // reset mid-operation
    pktReady = 1'b0;
    setInputs(4'b1111);
    step();
    setInputs(4'b0001);
    step();
    checkVal("t6level5", 64'(level), 64'd5);
    doReset();
    setInputs(4'b0000);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
